sos_cal_scheduler: RTL

SOS_CAL_SCHEDULER -- requirements
Module: sos_cal_scheduler

---
 rtl/sos_cal_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sos_cal_scheduler.sv
// rtl/sos_cal_scheduler.sv - speaker calibration sweep scheduler driving a distance calculator
//
// Walks channels 0..NUM_CH-1: settles, triggers the calculator, waits for a
// fresh delay_valid edge or a step-based timeout, retries with a calculator
// reset, and records per-channel delay / valid / fail results.
//
// Ports:
//   clk_in           system clock, all logic on posedge
//   rst_in           synchronous active-high reset
//   step_in          one-cycle sample-rate tick used for all timing
//   cal_req_in       sweep request, sampled every cycle
//   calc_delay_in    calculator delay result
//   calc_valid_in    calculator delay_valid level
//   calc_trigger_out one-cycle start pulse to the calculator
//   calc_rst_out     one-cycle abort pulse to the calculator
//   ch_sel_out       channel under measurement
//   busy_out         high while a sweep is in progress
//   delay_table_out  packed delays, channel k at [8k+7:8k]
//   ch_valid_out     per-channel result-good flags
//   ch_fail_out      per-channel gave-up flags
//   done_out         one-cycle pulse at sweep end
`timescale 1ns/1ps

module sos_cal_scheduler #(
    parameter int NUM_CH        = 4,
    parameter int SETTLE_STEPS  = 24,
    parameter int TIMEOUT_STEPS = 120000,
    parameter int MAX_RETRIES   = 2,
    parameter int PERIOD_STEPS  = 0
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                step_in,
    input  logic                cal_req_in,
    input  logic [7:0]          calc_delay_in,
    input  logic                calc_valid_in,
    output logic                calc_trigger_out,
    output logic                calc_rst_out,
    output logic [2:0]          ch_sel_out,
    output logic                busy_out,
    output logic [8*NUM_CH-1:0] delay_table_out,
    output logic [NUM_CH-1:0]   ch_valid_out,
    output logic [NUM_CH-1:0]   ch_fail_out,
    output logic                done_out
);

    // The step counter serves both SETTLE and WAIT, so it is sized for the
    // larger of the two limits; it can reach the limit itself without wrapping.
    localparam int STEP_MAX = (SETTLE_STEPS > TIMEOUT_STEPS) ? SETTLE_STEPS : TIMEOUT_STEPS;
    localparam int STEP_W   = (STEP_MAX > 0) ? $clog2(STEP_MAX + 1) : 1;
    localparam int RETRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int PER_W    = (PERIOD_STEPS > 0) ? $clog2(PERIOD_STEPS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TRIGGER,
        WAIT,
        RECOVER,
        NEXT
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [STEP_W-1:0]    step_cnt_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [PER_W-1:0]     period_cnt_q;
    logic [2:0]           ch_q;
    logic                 valid_prev_q;
    logic                 pending_q;
    logic [8*NUM_CH-1:0]  table_q;
    logic [NUM_CH-1:0]    ch_valid_q;
    logic [NUM_CH-1:0]    ch_fail_q;

    logic valid_edge;
    logic settle_done;
    logic timeout_hit;
    logic period_fire;
    logic start_sweep;
    logic last_ch;
    logic retry_ok;

    // Only a fresh rising edge counts, so a level left high by an earlier
    // attempt can never be mistaken for a new result.
    assign valid_edge  = calc_valid_in & ~valid_prev_q;
    assign settle_done = step_in && (step_cnt_q == STEP_W'(SETTLE_STEPS - 1));
    assign timeout_hit = step_in && (step_cnt_q == STEP_W'(TIMEOUT_STEPS - 1));
    assign period_fire = (PERIOD_STEPS > 0) && step_in && (period_cnt_q == PER_W'(PERIOD_STEPS - 1));
    assign start_sweep = (state_q == IDLE) && (cal_req_in || pending_q || period_fire);
    assign last_ch     = (ch_q == 3'(NUM_CH - 1));
    assign retry_ok    = (retry_q < RETRY_W'(MAX_RETRIES));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        calc_trigger_out = 1'b0;
        calc_rst_out     = 1'b0;
        done_out         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_sweep) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_d = TRIGGER;
                end
            end
            TRIGGER: begin
                calc_trigger_out = 1'b1;
                state_d          = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout tick is still taken.
                if (valid_edge) begin
                    state_d = NEXT;
                end else if (timeout_hit) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                calc_rst_out = 1'b1;
                state_d      = retry_ok ? SETTLE : NEXT;
            end
            NEXT: begin
                if (last_ch) begin
                    done_out = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            step_cnt_q   <= '0;
            retry_q      <= '0;
            period_cnt_q <= '0;
            ch_q         <= '0;
            valid_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            table_q      <= '0;
            ch_valid_q   <= '0;
            ch_fail_q    <= '0;
        end else begin
            valid_prev_q <= calc_valid_in;
            step_cnt_q   <= '0;

            if (cal_req_in && (state_q != IDLE)) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_sweep) begin
                        pending_q    <= 1'b0;
                        period_cnt_q <= '0;
                        ch_q         <= '0;
                        retry_q      <= '0;
                    end else if ((PERIOD_STEPS > 0) && step_in) begin
                        period_cnt_q <= period_cnt_q + PER_W'(1);
                    end
                end
                SETTLE: begin
                    step_cnt_q <= step_in ? step_cnt_q + STEP_W'(1) : step_cnt_q;
                end
                WAIT: begin
                    if (valid_edge) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_q == 3'(k)) begin
                                table_q[8*k +: 8] <= calc_delay_in;
                                ch_valid_q[k]     <= 1'b1;
                                ch_fail_q[k]      <= 1'b0;
                            end
                        end
                    end else begin
                        step_cnt_q <= step_in ? step_cnt_q + STEP_W'(1) : step_cnt_q;
                    end
                end
                RECOVER: begin
                    if (retry_ok) begin
                        retry_q <= retry_q + RETRY_W'(1);
                    end else begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_q == 3'(k)) begin
                                ch_valid_q[k] <= 1'b0;
                                ch_fail_q[k]  <= 1'b1;
                            end
                        end
                    end
                end
                NEXT: begin
                    if (!last_ch) begin
                        ch_q    <= ch_q + 3'd1;
                        retry_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ch_sel_out      = ch_q;
    assign busy_out        = (state_q != IDLE);
    assign delay_table_out = table_q;
    assign ch_valid_out    = ch_valid_q;
    assign ch_fail_out     = ch_fail_q;

endmodule
